ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RV32I pipeline, directly downstream of the ID/EX pipeline register and upstream of the EX/MEM register. It performs the following work:
- ALU arithmetic and logic.
- Branch resolution and jump-target generation, including younger-instruction flush.
- CSR write-data computation.
- Shifts, on an area-saving iterative shifter that requests a pipeline hold while busy.

## Interface
- SHIFT_STEP, default 4: bits shifted per cycle; legal values are 1, 2, 4 and 8.
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- stall, in, 1: global hold (memory wait). When high, EX/MEM and ID/EX do not advance.
- pc_in, in, 32: PC of the instruction in EX.
- pc4_in, in, 32: that PC + 4.
- data1_in, in, 32: rs1 operand, already forwarded.
- data2_in, in, 32: rs2 operand, already forwarded.
- funct7_in, in, 7: funct7 field.
- funct3_in, in, 3: funct3 field.
- opcode_in, in, 7: opcode field.
- imm_in, in, 32: sign-extended immediate; for CSRxI it carries the zero-extended uimm.
- z_in, in, 32: current CSR value, read in ID.
- wr_reg_n_in, in, 1: register-write request, active-low.
- wr_csr_n_in, in, 1: CSR-write request, active-low.
- flush_in, in, 1: the instruction is squashed.
- result, out, 32: rd value, or memory address for LOAD/STORE.
- store_data, out, 32: equals data2_in.
- csr_wdata, out, 32: new CSR value.
- wr_reg_n_out, out, 1: qualified register-write request to EX/MEM.
- wr_csr_n_out, out, 1: qualified CSR-write request to EX/MEM.
- flush_out, out, 1: taken branch or jump; flush IF/ID and ID/EX.
- target_pc, out, 32: redirect PC, valid when flush_out = 1.
- busy, out, 1: shifter occupied. The controller ORs busy into the ID/EX interlock and treats EX/MEM's input as a bubble.

## Operation
**Decoding**
- Opcodes handled: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, SYSTEM 1110011. Any other opcode gives result = 0 with both write enables forced inactive.
- Operand B is imm_in for OP-IMM, LOAD, STORE and AUIPC; otherwise it is data2_in.
- SUB is OP with funct7[5] = 1. SRA/SRAI is funct7[5] = 1.
- All arithmetic is modulo 2^32. SLT is signed, SLTU is unsigned.
- LUI: result = imm. AUIPC: result = pc + imm. LOAD/STORE: result = data1 + imm.

**Control flow**
- Branches compare data1 against data2:
  - BEQ/BNE: equality.
  - BLT/BGE: signed.
  - BLTU/BGEU: unsigned.
- Taken branch: target_pc = pc + imm.
- JAL: target_pc = pc + imm. JALR: target_pc = (data1 + imm) & ~1. Both give result = pc4.
- flush_out = taken branch or JAL or JALR, and only when flush_in = 0 and busy = 0.

**CSR**
- result = z_in.
- Source is data1 when funct3[2] = 0, else imm.
- csr_wdata:
  - CSRRW/CSRRWI: src.
  - CSRRS/CSRRSI: z_in | src.
  - CSRRC/CSRRCI: z_in & ~src.

**Write qualification**
- wr_reg_n_out = wr_reg_n_eff | flush_in | busy.
- wr_csr_n_out = wr_csr_n_in | flush_in.
- wr_reg_n_eff is wr_reg_n_in, except in DONE, where the value latched at shift start is used.

**Shifter FSM (sub-module)**
- States: IDLE, SHIFT, DONE.
- shamt is data2[4:0] for OP or imm[4:0] for OP-IMM.
- IDLE:
  - A shift with flush_in = 0 and shamt ≠ 0 loads the operand, shamt, direction and wr_reg_n_in into registers and moves to SHIFT. busy is high in that same cycle (combinational).
  - A shift with shamt = 0 gives result = data1 with no FSM entry.
- SHIFT:
  - Each cycle, shift by min(SHIFT_STEP, remaining) and decrement remaining.
  - Moving to DONE when remaining reaches 0.
  - SRA fills with the sign bit; SLL and SRL fill with 0.
- DONE:
  - busy = 0 and result = the shift register contents.
  - The write enable comes from the latched value, because ID/EX deasserts wr_reg_n while held.
  - At a clock edge with stall = 0, return to IDLE (ID/EX loads the next instruction at that edge).
  - With stall = 1, hold in DONE.
- stall has no effect on SHIFT progress.

## Timing
- All non-shift paths are combinational from the inputs. Shifts with shamt = 0 are also combinational.
- Shift latency: busy is high for ceil(shamt / SHIFT_STEP) cycles, starting in the issue cycle; the result is presented in the following DONE cycle.
- With SHIFT_STEP = 4, shamt = 31 gives busy for 8 cycles.
- Reset (asynchronous, applied mid-operation included): FSM returns to IDLE and shift registers clear to 0. While rst_n = 0:
  - busy = 0
  - flush_out = 0
  - wr_reg_n_out = 1
  - wr_csr_n_out = 1
  - result, csr_wdata and target_pc follow their inputs.
- A shift arriving with flush_in = 1 never starts the FSM.

## Structure
- Shared package rv32i_pkg holds:
  - opcode localparams (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM);
  - funct3 constants for ALU, branch and CSR operations;
  - the shifter state enum.
- Sub-module ex_serial_shifter (parameter SHIFT_STEP) contains the FSM, the operand/count registers and the latched write enable. It exports busy, done and the shift result.

## Test plan
- ADD 5 + (−7) → result 0xFFFFFFFE. SLTU 1 vs 0xFFFFFFFF → 1. SLT with the same operands → 0. busy stays 0.
- BLT −1 < 1 at pc 0x100, imm 0x20 → flush_out = 1, target_pc = 0x120. The same branch with flush_in = 1 → flush_out = 0.
- JALR: data1 = 0x1003, imm 4 → target_pc = 0x1006, result = pc4.
- SRAI 0x80000000 by 31 with SHIFT_STEP = 4 → busy for 8 cycles with wr_reg_n_out = 1, then DONE with result 0xFFFFFFFF and wr_reg_n_out = 0 while wr_reg_n_in = 1. Holding stall = 1 keeps DONE.
- CSRRC: z_in = 0xFF, data1 = 0x0F → csr_wdata = 0xF0, result = 0xFF. CSRRSI with uimm 0x10 → csr_wdata = 0xFF | 0x10.
- Assert rst_n low during SHIFT → busy drops immediately. After release, the FSM is IDLE and a SLL 1 by 0 gives result 1 combinationally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants, the shifter state type and a fixed-amount shift helper.
package rv32i_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // CSR op is funct3[1:0]; funct3[2] selects the immediate source
  localparam logic [1:0] CSR_RW = 2'b01;
  localparam logic [1:0] CSR_RS = 2'b10;
  localparam logic [1:0] CSR_RC = 2'b11;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } shift_state_e;

  // Separate branches keep the arithmetic shift in a signed context
  function automatic logic [31:0] shift_by(input logic [31:0] x, input logic [4:0] k,
                                           input logic left, input logic arith);
    logic [31:0] r;
    if (left)       r = x << k;
    else if (arith) r = $signed(x) >>> k;
    else            r = x >> k;
    return r;
  endfunction

endpackage

// File: rtl/ex_serial_shifter.sv
// Iterative shifter: SHIFT_STEP bits per cycle, holds the pipeline via busy until DONE.
//   state    | meaning
//   SH_IDLE  | no shift in flight; a start performs the first step and loads the registers
//   SH_SHIFT | remaining steps in progress, busy high, stall ignored
//   SH_DONE  | result valid, waits for a stall-free edge to release the instruction
module ex_serial_shifter
  import rv32i_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        start,
  input  logic [31:0] operand,
  input  logic [4:0]  shamt,
  input  logic        dir_left,
  input  logic        arith,
  input  logic        wr_reg_n_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] shift_result,
  output logic        wr_reg_n_lat
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  shift_state_e state_q, state_d;
  logic [31:0]  sreg_q, sreg_d;
  logic [4:0]   remain_q, remain_d;
  logic         left_q, left_d;
  logic         arith_q, arith_d;
  logic         wrn_q, wrn_d;
  logic [4:0]   step_amt;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    remain_d = remain_q;
    left_d   = left_q;
    arith_d  = arith_q;
    wrn_d    = wrn_q;
    step_amt = '0;
    case (state_q)
      SH_IDLE: begin
        if (start) begin
          // The issue cycle already shifts, so busy lasts exactly ceil(shamt/STEP) cycles
          step_amt = (shamt > STEP) ? STEP : shamt;
          sreg_d   = shift_by(operand, step_amt, dir_left, arith);
          remain_d = shamt - step_amt;
          left_d   = dir_left;
          arith_d  = arith;
          wrn_d    = wr_reg_n_in;
          state_d  = (shamt > STEP) ? SH_SHIFT : SH_DONE;
        end
      end
      SH_SHIFT: begin
        step_amt = (remain_q > STEP) ? STEP : remain_q;
        sreg_d   = shift_by(sreg_q, step_amt, left_q, arith_q);
        remain_d = remain_q - step_amt;
        if (remain_q <= STEP) state_d = SH_DONE;
      end
      SH_DONE: begin
        if (!stall) state_d = SH_IDLE;
      end
      default: state_d = SH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SH_IDLE;
      sreg_q   <= '0;
      remain_q <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
      wrn_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      remain_q <= remain_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
      wrn_q    <= wrn_d;
    end
  end

  assign busy         = ((state_q == SH_IDLE) && start) || (state_q == SH_SHIFT);
  assign done         = (state_q == SH_DONE);
  assign shift_result = sreg_q;
  assign wr_reg_n_lat = wrn_q;

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, CSR write data and write qualification.
module ex_stage
  import rv32i_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic [6:0]  funct7_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  opcode_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] z_in,
  input  logic        wr_reg_n_in,
  input  logic        wr_csr_n_in,
  input  logic        flush_in,
  output logic [31:0] result,
  output logic [31:0] store_data,
  output logic [31:0] csr_wdata,
  output logic        wr_reg_n_out,
  output logic        wr_csr_n_out,
  output logic        flush_out,
  output logic [31:0] target_pc,
  output logic        busy
);

  logic        is_op, is_opimm, is_shift, known_op, use_imm, jump, taken;
  logic        sh_start, sh_busy, sh_done, sh_wrn_lat, wr_reg_n_eff;
  logic [4:0]  shamt;
  logic [31:0] op_b, sh_result, alu_res, csr_src, res_d;
  logic        unused_bits;

  assign is_op    = (opcode_in == OP);
  assign is_opimm = (opcode_in == OP_IMM);
  assign use_imm  = is_opimm || (opcode_in == LOAD) || (opcode_in == STORE) || (opcode_in == AUIPC);
  assign op_b     = use_imm ? imm_in : data2_in;
  assign known_op = is_op || is_opimm || (opcode_in == LUI) || (opcode_in == AUIPC) ||
                    (opcode_in == JAL) || (opcode_in == JALR) || (opcode_in == BRANCH) ||
                    (opcode_in == LOAD) || (opcode_in == STORE) || (opcode_in == SYSTEM);

  assign shamt    = is_op ? data2_in[4:0] : imm_in[4:0];
  assign is_shift = (is_op || is_opimm) && ((funct3_in == F3_SLL) || (funct3_in == F3_SR));
  // Gating with rst_n keeps busy low while reset is held
  assign sh_start = rst_n && is_shift && !flush_in && (shamt != 5'd0);

  ex_serial_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .start        (sh_start),
    .operand      (data1_in),
    .shamt        (shamt),
    .dir_left     (funct3_in == F3_SLL),
    .arith        (funct7_in[5]),
    .wr_reg_n_in  (wr_reg_n_in),
    .busy         (sh_busy),
    .done         (sh_done),
    .shift_result (sh_result),
    .wr_reg_n_lat (sh_wrn_lat)
  );

  always_comb begin
    alu_res = '0;
    case (funct3_in)
      F3_ADD:        alu_res = (is_op && funct7_in[5]) ? (data1_in - op_b) : (data1_in + op_b);
      F3_SLL, F3_SR: alu_res = (shamt == 5'd0) ? data1_in : sh_result;
      F3_SLT:        alu_res = {31'd0, $signed(data1_in) < $signed(op_b)};
      F3_SLTU:       alu_res = {31'd0, data1_in < op_b};
      F3_XOR:        alu_res = data1_in ^ op_b;
      F3_OR:         alu_res = data1_in | op_b;
      F3_AND:        alu_res = data1_in & op_b;
      default:       alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3_in)
      F3_BEQ:  taken = (data1_in == data2_in);
      F3_BNE:  taken = (data1_in != data2_in);
      F3_BLT:  taken = ($signed(data1_in) < $signed(data2_in));
      F3_BGE:  taken = ($signed(data1_in) >= $signed(data2_in));
      F3_BLTU: taken = (data1_in < data2_in);
      F3_BGEU: taken = (data1_in >= data2_in);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    res_d = '0;
    case (opcode_in)
      OP, OP_IMM:  res_d = alu_res;
      LUI:         res_d = imm_in;
      AUIPC:       res_d = pc_in + imm_in;
      JAL, JALR:   res_d = pc4_in;
      LOAD, STORE: res_d = data1_in + imm_in;
      SYSTEM:      res_d = z_in;
      default:     res_d = '0;
    endcase
    // In DONE the instruction is still held in EX; present the finished shift
    if (sh_done) res_d = sh_result;
  end

  assign csr_src = funct3_in[2] ? imm_in : data1_in;
  always_comb begin
    csr_wdata = z_in;
    case (funct3_in[1:0])
      CSR_RW:  csr_wdata = csr_src;
      CSR_RS:  csr_wdata = z_in | csr_src;
      CSR_RC:  csr_wdata = z_in & ~csr_src;
      default: csr_wdata = z_in;
    endcase
  end

  assign jump      = (opcode_in == JAL) || (opcode_in == JALR);
  assign target_pc = (opcode_in == JALR) ? ((data1_in + imm_in) & ~32'h1) : (pc_in + imm_in);
  assign flush_out = rst_n && !flush_in && !sh_busy &&
                     (jump || ((opcode_in == BRANCH) && taken));

  assign wr_reg_n_eff = sh_done ? sh_wrn_lat : wr_reg_n_in;
  assign wr_reg_n_out = !rst_n || !known_op || wr_reg_n_eff || flush_in || sh_busy;
  assign wr_csr_n_out = !rst_n || !known_op || wr_csr_n_in || flush_in;

  assign result      = res_d;
  assign store_data  = data2_in;
  assign busy        = sh_busy;
  assign unused_bits = ^{funct7_in[6], funct7_in[4:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a whole-instruction reference model.
module tb_ex_stage;
  import rv32i_pkg::*;

  localparam int STEP = 4;

  logic        clk, rst_n, stall;
  logic [31:0] pc_in, pc4_in, data1_in, data2_in, imm_in, z_in;
  logic [6:0]  funct7_in, opcode_in;
  logic [2:0]  funct3_in;
  logic        wr_reg_n_in, wr_csr_n_in, flush_in;
  logic [31:0] result, store_data, csr_wdata, target_pc;
  logic        wr_reg_n_out, wr_csr_n_out, flush_out, busy;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_in(pc_in), .pc4_in(pc4_in),
    .data1_in(data1_in), .data2_in(data2_in), .funct7_in(funct7_in), .funct3_in(funct3_in),
    .opcode_in(opcode_in), .imm_in(imm_in), .z_in(z_in), .wr_reg_n_in(wr_reg_n_in),
    .wr_csr_n_in(wr_csr_n_in), .flush_in(flush_in), .result(result), .store_data(store_data),
    .csr_wdata(csr_wdata), .wr_reg_n_out(wr_reg_n_out), .wr_csr_n_out(wr_csr_n_out),
    .flush_out(flush_out), .target_pc(target_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [31:0] csr;
    logic [31:0] tgt;
    logic        fl;
    logic        wrn;
    logic        wcn;
  } exp_t;

  // Architectural behaviour of one non-stalling instruction
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic [31:0] z,
                                 input logic wrn, input logic wcn, input logic fl);
    exp_t e;
    logic [31:0] b, src;
    logic signed [31:0] sd1;
    logic redirect, known;
    redirect = 1'b0;
    known    = 1'b1;
    e.res    = 32'd0;
    e.tgt    = pc + imm;
    b   = (op == OP_IMM || op == LOAD || op == STORE || op == AUIPC) ? imm : d2;
    sd1 = d1;
    case (op)
      OP, OP_IMM: begin
        case (f3)
          3'd0: e.res = (op == OP && f7[5]) ? d1 - b : d1 + b;
          3'd1: e.res = d1 << b[4:0];
          3'd2: e.res = ($signed(d1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: e.res = (d1 < b) ? 32'd1 : 32'd0;
          3'd4: e.res = d1 ^ b;
          3'd5: if (f7[5]) e.res = sd1 >>> b[4:0]; else e.res = d1 >> b[4:0];
          3'd6: e.res = d1 | b;
          default: e.res = d1 & b;
        endcase
      end
      LUI:   e.res = imm;
      AUIPC: e.res = pc + imm;
      JAL:   begin e.res = pc + 32'd4; redirect = 1'b1; end
      JALR:  begin e.res = pc + 32'd4; redirect = 1'b1; e.tgt = (d1 + imm) & 32'hFFFF_FFFE; end
      BRANCH: begin
        case (f3)
          3'd0: redirect = (d1 == d2);
          3'd1: redirect = (d1 != d2);
          3'd4: redirect = ($signed(d1) < $signed(d2));
          3'd5: redirect = !($signed(d1) < $signed(d2));
          3'd6: redirect = (d1 < d2);
          3'd7: redirect = !(d1 < d2);
          default: redirect = 1'b0;
        endcase
      end
      LOAD, STORE: e.res = d1 + imm;
      SYSTEM: e.res = z;
      default: known = 1'b0;
    endcase
    src = f3[2] ? imm : d1;
    case (f3[1:0])
      2'd1:    e.csr = src;
      2'd2:    e.csr = z | src;
      2'd3:    e.csr = z & ~src;
      default: e.csr = z;
    endcase
    e.fl  = redirect && !fl;
    e.wrn = wrn || fl || !known;
    e.wcn = wcn || fl || !known;
    return e;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    opcode_in = op; funct3_in = f3; funct7_in = f7;
    data1_in = d1; data2_in = d2; imm_in = imm;
  endtask

  // Issue one shift and follow it through busy, DONE (with a stall hold) and back to IDLE
  task automatic run_shift(input logic [31:0] a, input logic [4:0] sh, input int kind,
                           input logic imm_form, input logic wrn0, input int hold);
    logic [31:0] exp_v, nop_a, nop_b;
    logic signed [31:0] as;
    int cyc, exp_cyc;
    as = a;
    if (kind == 0)      exp_v = a << sh;
    else if (kind == 1) exp_v = a >> sh;
    else                exp_v = as >>> sh;
    exp_cyc = (int'(sh) + STEP - 1) / STEP;
    @(negedge clk);
    drive(imm_form ? OP_IMM : OP, (kind == 0) ? 3'b001 : 3'b101,
          (kind == 2) ? 7'b0100000 : 7'b0000000, a,
          imm_form ? $urandom : {$urandom_range(0, 32'h07FF_FFFF), 5'b0} | {27'd0, sh},
          imm_form ? {27'd0, sh} : $urandom);
    wr_reg_n_in = wrn0; flush_in = 1'b0; stall = 1'b0;
    #1;
    cyc = 0;
    while (busy && cyc < 64) begin
      cyc++;
      check("shift_busy_wr", {31'd0, wr_reg_n_out}, 32'd1);
      @(negedge clk);
      wr_reg_n_in = 1'b1;
      stall = 1'($urandom_range(0, 1));
      #1;
    end
    check("shift_cycles", cyc, exp_cyc);
    check("shift_result", result, exp_v);
    check("shift_done_wr", {31'd0, wr_reg_n_out}, {31'd0, wrn0});
    stall = 1'b1;
    repeat (hold) begin
      @(negedge clk); #1;
      check("shift_hold_res", result, exp_v);
      check("shift_hold_busy", {31'd0, busy}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    nop_a = $urandom; nop_b = $urandom;
    drive(OP, 3'b000, 7'b0, nop_a, nop_b, 32'd0);
    wr_reg_n_in = 1'b0;
    #1;
    check("after_shift_busy", {31'd0, busy}, 32'd0);
    check("after_shift_res", result, nop_a + nop_b);
  endtask

  initial begin
    logic [6:0] ops [11];
    exp_t e;
    ops = '{OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM, 7'b1111111};

    rst_n = 1'b0; stall = 1'b0; flush_in = 1'b0;
    pc_in = 32'h100; pc4_in = 32'h104; z_in = 32'd0;
    wr_reg_n_in = 1'b0; wr_csr_n_in = 1'b0;
    drive(OP, 3'b000, 7'b0, 32'd5, 32'hFFFF_FFF9, 32'd0);
    #2;
    check("rst_result", result, 32'hFFFF_FFFE);
    check("rst_wrn", {31'd0, wr_reg_n_out}, 32'd1);
    check("rst_wcn", {31'd0, wr_csr_n_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    drive(JAL, 3'b000, 7'b0, 32'd0, 32'd0, 32'h40);
    #1;
    check("rst_flush", {31'd0, flush_out}, 32'd0);
    check("rst_target", target_pc, 32'h140);
    drive(OP_IMM, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'd31);
    #1;
    check("rst_shift_busy", {31'd0, busy}, 32'd0);

    @(negedge clk); rst_n = 1'b1;
    drive(OP, 3'b000, 7'b0, 32'd5, 32'hFFFF_FFF9, 32'd0);
    #1;
    check("add", result, 32'hFFFF_FFFE);
    check("add_wrn", {31'd0, wr_reg_n_out}, 32'd0);
    drive(OP, 3'b011, 7'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    #1;
    check("sltu", result, 32'd1);
    drive(OP, 3'b010, 7'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    #1;
    check("slt", result, 32'd0);
    check("alu_busy", {31'd0, busy}, 32'd0);

    drive(BRANCH, 3'b100, 7'b0, 32'hFFFF_FFFF, 32'd1, 32'h20);
    #1;
    check("blt_flush", {31'd0, flush_out}, 32'd1);
    check("blt_target", target_pc, 32'h120);
    flush_in = 1'b1;
    #1;
    check("blt_squashed", {31'd0, flush_out}, 32'd0);
    flush_in = 1'b0;

    drive(JALR, 3'b000, 7'b0, 32'h1003, 32'd0, 32'd4);
    #1;
    check("jalr_target", target_pc, 32'h1006);
    check("jalr_result", result, 32'h104);
    check("jalr_flush", {31'd0, flush_out}, 32'd1);

    z_in = 32'hFF;
    drive(SYSTEM, 3'b011, 7'b0, 32'h0F, 32'd0, 32'd0);
    #1;
    check("csrrc_wdata", csr_wdata, 32'hF0);
    check("csrrc_result", result, 32'hFF);
    drive(SYSTEM, 3'b110, 7'b0, 32'h0F, 32'd0, 32'h10);
    #1;
    check("csrrsi_wdata", csr_wdata, 32'hFF);

    run_shift(32'h8000_0000, 5'd31, 2, 1'b1, 1'b0, 3);

    // A squashed shift must not start the FSM
    @(negedge clk);
    drive(OP_IMM, 3'b001, 7'b0, 32'h1234, 32'd0, 32'd5);
    flush_in = 1'b1;
    #1;
    check("flushed_shift_busy", {31'd0, busy}, 32'd0);
    check("flushed_shift_wrn", {31'd0, wr_reg_n_out}, 32'd1);
    @(negedge clk);
    flush_in = 1'b0;
    drive(OP, 3'b000, 7'b0, 32'd3, 32'd4, 32'd0);
    #1;
    check("flushed_shift_idle", {31'd0, busy}, 32'd0);
    check("flushed_shift_res", result, 32'd7);

    // Reset in the middle of a long shift
    @(negedge clk);
    drive(OP_IMM, 3'b101, 7'b0, 32'hF000_0000, 32'd0, 32'd31);
    wr_reg_n_in = 1'b0;
    #1;
    check("mid_issue_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("mid_shift_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_flush", {31'd0, flush_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP, 3'b001, 7'b0, 32'd1, 32'd0, 32'd0);
    #1;
    check("post_rst_sll0", result, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Random non-stalling instructions (shift amounts forced to zero)
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      opcode_in   = ops[$urandom_range(0, 10)];
      funct3_in   = 3'($urandom);
      funct7_in   = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000;
      data1_in    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      data2_in    = ($urandom_range(0, 3) == 0) ? data1_in : $urandom;
      imm_in      = $urandom;
      pc_in       = $urandom & 32'hFFFF_FFFC;
      pc4_in      = pc_in + 32'd4;
      z_in        = $urandom;
      wr_reg_n_in = 1'($urandom);
      wr_csr_n_in = 1'($urandom);
      flush_in    = ($urandom_range(0, 4) == 0);
      stall       = 1'($urandom);
      if ((opcode_in == OP || opcode_in == OP_IMM) && (funct3_in == 3'b001 || funct3_in == 3'b101)) begin
        if (opcode_in == OP) data2_in[4:0] = 5'd0;
        else                 imm_in[4:0]   = 5'd0;
      end
      e = model(opcode_in, funct3_in, funct7_in, pc_in, data1_in, data2_in, imm_in, z_in,
                wr_reg_n_in, wr_csr_n_in, flush_in);
      #1;
      if (opcode_in != BRANCH) check("rnd_result", result, e.res);
      if (opcode_in == SYSTEM && funct3_in[1:0] != 2'b00) check("rnd_csr", csr_wdata, e.csr);
      check("rnd_flush", {31'd0, flush_out}, {31'd0, e.fl});
      if (e.fl) check("rnd_target", target_pc, e.tgt);
      check("rnd_wrn", {31'd0, wr_reg_n_out}, {31'd0, e.wrn});
      check("rnd_wcn", {31'd0, wr_csr_n_out}, {31'd0, e.wcn});
      check("rnd_busy", {31'd0, busy}, 32'd0);
      check("rnd_store", store_data, data2_in);
    end
    stall = 1'b0; flush_in = 1'b0;

    // Random multi-cycle shifts
    for (int i = 0; i < 24; i++) begin
      run_shift($urandom, 5'($urandom_range(1, 31)), $urandom_range(0, 2),
                1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
